// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        FREE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int unsigned NBYTES  = 3;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = NBYTES * BYTE_W;
    localparam logic        RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator; clear restarts the count, hold freezes it.
module i2c_tick_gen #(
    parameter int unsigned QDIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CNT_W = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == CNT_W'(QDIV - 1));
    assign tick   = at_end && !hold && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= at_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Single-master I2C 3-byte write engine (address+W, data_0, data_1).
// Define I2C_CLK_STRETCH_EN to let the slave stretch SCL during BIT/ACK high phases.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned I2C_HZ = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] address,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic       scl_i
);

    localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);

    if (QDIV < 2) begin : g_qdiv_check
        $error("i2c_write_master: QDIV must be at least 2");
    end

    state_t               state, state_nxt;
    logic [1:0]           qph, qph_nxt;
    logic [FRAME_W-1:0]   sh, sh_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [1:0]           byte_idx, byte_idx_nxt;
    logic                 ack_smp, ack_smp_nxt;
    logic                 ack_error_nxt, done_nxt, scl_nxt, sda_nxt;
    logic                 accept, tick, hold, step, last_q;

    assign accept = start && (state == IDLE);
    assign busy   = (state != IDLE) || start;

`ifdef I2C_CLK_STRETCH_EN
    // Only a low SCL that we are not pulling ourselves counts as stretching.
    assign hold = ((state == BIT) || (state == ACK)) && qph[1] && !scl_oe && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign hold = 1'b0;
`endif

    i2c_tick_gen #(.QDIV(QDIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .hold  (hold),
        .tick  (tick)
    );

    assign step   = tick && (state != IDLE);
    assign last_q = step && (qph == Q3);

    // Next-state and next-output logic; line levels follow the current quarter.
    always_comb begin
        state_nxt     = state;
        qph_nxt       = qph;
        sh_nxt        = sh;
        bit_idx_nxt   = bit_idx;
        byte_idx_nxt  = byte_idx;
        ack_smp_nxt   = ack_smp;
        ack_error_nxt = ack_error;
        done_nxt      = 1'b0;
        scl_nxt       = 1'b0;
        sda_nxt       = 1'b0;

        if (step) begin
            qph_nxt = qph + 2'd1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = START;
                    qph_nxt       = Q0;
                    sh_nxt        = {address, RW_WRITE, data_0, data_1};
                    bit_idx_nxt   = '0;
                    byte_idx_nxt  = '0;
                    ack_error_nxt = 1'b0;
                end
            end
            START: begin
                sda_nxt = (qph != Q0);
                scl_nxt = (qph == Q3);
                if (last_q) begin
                    state_nxt = BIT;
                end
            end
            BIT: begin
                scl_nxt = !qph[1];
                sda_nxt = !sh[FRAME_W-1];
                if (last_q) begin
                    sh_nxt = {sh[FRAME_W-2:0], 1'b0};
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = ACK;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            ACK: begin
                scl_nxt = !qph[1];
                if (step && (qph == Q2)) begin
                    ack_smp_nxt = sda_i;
                end
                if (last_q) begin
                    if (ack_smp) begin
                        ack_error_nxt = 1'b1;
                        state_nxt     = STOP;
                    end else if (byte_idx == 2'(NBYTES - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        byte_idx_nxt = byte_idx + 2'd1;
                        state_nxt    = BIT;
                    end
                end
            end
            STOP: begin
                scl_nxt = (qph == Q0);
                sda_nxt = !qph[1];
                if (last_q) begin
                    state_nxt = FREE;
                end
            end
            FREE: begin
                if (last_q) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            qph       <= Q0;
            sh        <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            ack_smp   <= 1'b0;
            ack_error <= 1'b0;
            done      <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_nxt;
            qph       <= qph_nxt;
            sh        <= sh_nxt;
            bit_idx   <= bit_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            ack_smp   <= ack_smp_nxt;
            ack_error <= ack_error_nxt;
            done      <= done_nxt;
            scl_oe    <= scl_nxt;
            sda_oe    <= sda_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus-level slave/decoder with a byte scoreboard.
// Define I2C_CLK_STRETCH_EN to also exercise slave clock stretching.
module tb_i2c_write_master;

    localparam int QDIV    = 125;
    localparam int PERIOD  = 4 * QDIV;
    localparam int STRETCH = 300;
    localparam int TMO     = 20000;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [6:0] address;
    logic [7:0] data_0, data_1;
    logic       busy, done, ack_error, scl_oe, sda_oe;
    logic       sda_i, scl_i;

    logic slave_pull   = 1'b0;
    logic stretch_pull = 1'b0;

    assign sda_i = ~(sda_oe | slave_pull);
    assign scl_i = ~(scl_oe | stretch_pull);

    i2c_write_master #(.CLK_HZ(50000000), .I2C_HZ(100000)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .address   (address),
        .data_0    (data_0),
        .data_1    (data_1),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i),
        .scl_i     (scl_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard of bytes expected on the wire, in order.
    logic [7:0] exp_q[$];

    // Bus monitor / slave model state.
    int   nack_byte   = 3;
    bit   stretch_req = 1'b0;
    bit   stretched   = 1'b0;
    int   stretch_cnt = 0;
    bit   in_txn      = 1'b0;
    int   mon_starts  = 0;
    int   mon_stops   = 0;
    int   bytes_seen  = 0;
    int   bitcnt      = 0;
    int   last_rise   = 0;
    logic [7:0] shreg = '0;
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;

    initial begin : monitor
        logic scl_l, sda_l;
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_pull   = 1'b0;
                stretch_pull = 1'b0;
                in_txn       = 1'b0;
                prev_scl     = 1'b1;
                prev_sda     = 1'b1;
                prev_scl_oe  = 1'b0;
            end else begin
`ifdef I2C_CLK_STRETCH_EN
                if (stretch_pull) begin
                    stretch_cnt--;
                    if (stretch_cnt == 0) stretch_pull = 1'b0;
                end else if (stretch_req && in_txn && prev_scl_oe && !scl_oe &&
                             bytes_seen == 1 && bitcnt == 3) begin
                    stretch_pull = 1'b1;
                    stretch_cnt  = STRETCH;
                    stretched    = 1'b1;
                    stretch_req  = 1'b0;
                end
`endif
                scl_l = ~(scl_oe | stretch_pull);
                sda_l = ~(sda_oe | slave_pull);
                if (prev_scl && scl_l && prev_sda && !sda_l) begin
                    in_txn     = 1'b1;
                    bitcnt     = 0;
                    bytes_seen = 0;
                    mon_starts++;
                end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
                    in_txn     = 1'b0;
                    slave_pull = 1'b0;
                    mon_stops++;
                end else if (!prev_scl && scl_l && in_txn) begin
                    if (bitcnt != 0)
                        chk("scl_period", 32'(cyc - last_rise), 32'(PERIOD + (stretched ? STRETCH : 0)));
                    stretched = 1'b0;
                    last_rise = cyc;
                    if (bitcnt < 8) begin
                        shreg = {shreg[6:0], sda_l};
                        bitcnt++;
                        if (bitcnt == 8) begin
                            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                            if (exp_q.size() != 0) chk("wire_byte", 32'(shreg), 32'(exp_q.pop_front()));
                        end
                    end else begin
                        chk("ack_slot", 32'(sda_l), 32'(bytes_seen == nack_byte));
                        bitcnt = 0;
                        bytes_seen++;
                    end
                end else if (prev_scl && !scl_l && in_txn) begin
                    slave_pull = (bitcnt == 8) && (bytes_seen != nack_byte);
                end
                prev_scl    = scl_l;
                prev_sda    = sda_l;
                prev_scl_oe = scl_oe;
            end
        end
    end

    task automatic launch(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1,
                          input int nack_at, input bit str);
        int nb;
        nb = (nack_at < 3) ? nack_at + 1 : 3;
        exp_q.push_back({a, 1'b0});
        if (nb > 1) exp_q.push_back(d0);
        if (nb > 2) exp_q.push_back(d1);
        nack_byte   = nack_at;
        stretch_req = str;
        mon_starts  = 0;
        mon_stops   = 0;
        start   = 1'b1;
        address = a;
        data_0  = d0;
        data_1  = d1;
        #1 chk("busy_in_start_cycle", 32'(busy), 32'd1);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1,
                           input int nack_at, input int start_len, input bit str);
        int nb, lat, acc_cyc, busy_low;
        bit got_done;
        nb  = (nack_at < 3) ? nack_at + 1 : 3;
        lat = (12 + 36 * nb) * QDIV + (str ? STRETCH : 0);
        @(negedge clk); #1;
        launch(a, d0, d1, nack_at, str);
        @(negedge clk); #1;
        acc_cyc  = cyc;
        busy_low = 0;
        chk("ack_error_clear_on_accept", 32'(ack_error), 32'd0);
        for (int i = 1; i < start_len; i++) begin
            address = ~a;
            data_0  = ~d0;
            data_1  = ~d1;
            if (!busy) busy_low++;
            @(negedge clk); #1;
        end
        start   = 1'b0;
        address = 7'h55;
        data_0  = 8'hC3;
        data_1  = 8'h3C;
        got_done = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (!busy) busy_low++;
            @(negedge clk); #1;
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("done_latency", 32'(cyc - acc_cyc), 32'(lat));
        chk("busy_through_txn", 32'(busy_low), 32'd0);
        chk("ack_error", 32'(ack_error), 32'(nack_at < 3));
        chk("bytes_left", 32'(exp_q.size()), 32'd0);
        chk("start_conditions", 32'(mon_starts), 32'd1);
        chk("stop_conditions", 32'(mon_stops), 32'd1);
        @(negedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ack_error_sticky", 32'(ack_error), 32'(nack_at < 3));
    endtask

    initial begin : stim
        bit hit;
        rst     = 1'b1;
        start   = 1'b0;
        address = '0;
        data_0  = '0;
        data_1  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_error", 32'(ack_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Nominal write, all bytes acknowledged.
        run_txn(7'h39, 8'h41, 8'h10, 3, 1, 1'b0);

        // Address NACK: only the address byte goes out.
        run_txn(7'h50, 8'hAA, 8'h55, 0, 1, 1'b0);
        repeat (20) @(negedge clk);
        #1 chk("ack_error_holds", 32'(ack_error), 32'd1);

        // Idle reset clears the sticky flag.
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_clears_ack_error", 32'(ack_error), 32'd0);
        rst = 1'b0;

        // start held for three cycles; stretched bit when the feature is built in.
`ifdef I2C_CLK_STRETCH_EN
        run_txn(7'h2A, 8'h5A, 8'hA5, 3, 3, 1'b1);
`else
        run_txn(7'h2A, 8'h5A, 8'hA5, 3, 3, 1'b0);
`endif

        // Reset in quarter 2 of bit 4 of data_0.
        @(negedge clk); #1;
        launch(7'h39, 8'h41, 8'h10, 3, 1'b0);
        @(negedge clk); #1;
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            if (bytes_seen == 1 && bitcnt == 5) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("reached_bit4", 32'(hit), 32'd1);
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst_scl_oe", 32'(scl_oe), 32'd0);
        chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack_error", 32'(ack_error), 32'd0);
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        run_txn(7'h39, 8'h41, 8'h10, 3, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
